// File: rtl/def.sv
// Decoded instruction codes shared by the pipeline stages.
// Only the load/store codes matter to the memory stage; everything else is a no-op there.
package def_pkg;
  localparam logic [5:0] INST_ADD = 6'h01;
  localparam logic [5:0] INST_LH  = 6'h10;
  localparam logic [5:0] INST_LHU = 6'h11;
  localparam logic [5:0] INST_LW  = 6'h12;
  localparam logic [5:0] INST_SH  = 6'h13;
  localparam logic [5:0] INST_SW  = 6'h14;
endpackage

// File: rtl/mem_pkg.sv
// Types and helpers for the memory-access stage: FSM states and operation classes.
package mem_pkg;
  import def_pkg::*;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} mem_state_t;

  typedef enum logic [2:0] {
    BYTE_LOAD_S, BYTE_LOAD_U, WORD_LOAD, BYTE_STORE, WORD_STORE, NOP
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] inst);
    case (inst)
      INST_LH:  return BYTE_LOAD_S;
      INST_LHU: return BYTE_LOAD_U;
      INST_LW:  return WORD_LOAD;
      INST_SH:  return BYTE_STORE;
      INST_SW:  return WORD_STORE;
      default:  return NOP;
    endcase
  endfunction

  function automatic logic is_word(input op_class_t c);
    return (c == WORD_LOAD) || (c == WORD_STORE);
  endfunction

  function automatic logic is_store(input op_class_t c);
    return (c == BYTE_STORE) || (c == WORD_STORE);
  endfunction

  function automatic logic is_load(input op_class_t c);
    return (c == BYTE_LOAD_S) || (c == BYTE_LOAD_U) || (c == WORD_LOAD);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// Byte-wide request/acknowledge memory bus.
// Handshake: master holds mem_req with stable mem_addr/mem_we/mem_wdata until it samples mem_ack high;
// read data on mem_rdata is valid in the ack cycle; mem_ack without mem_req has no effect.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_load_extend.sv
// Builds the 16-bit load result from the captured bytes according to the operation class.
module load_extend
  import mem_pkg::*;
(
  input  op_class_t   op_i,
  input  logic [7:0]  byte_lo_i,
  input  logic [7:0]  byte_hi_i,
  output logic [15:0] rdata_o
);
  always_comb begin
    rdata_o = {8'h00, byte_lo_i};
    case (op_i)
      BYTE_LOAD_S: rdata_o = {{8{byte_lo_i[7]}}, byte_lo_i};
      WORD_LOAD:   rdata_o = {byte_hi_i, byte_lo_i};
      default:     ;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: runs LH/LHU/LW/SH/SW as one or two little-endian byte transactions
// on the request/acknowledge bus and returns the extended load result.
module mem_access
  import mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   d_inst,
  input  logic [15:0]  addr,
  input  logic [15:0]  wdata,
  output logic         busy,
  output logic         done,
  output logic [15:0]  rdata,
  mem_access_if.master bus,
  output mem_state_t   state_o
);
  mem_state_t  state_q;
  op_class_t   op_q;
  op_class_t   start_op_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_hi_q;
  logic [7:0]  lo_q;
  logic [7:0]  byte_lo_d;
  logic [15:0] rdata_d;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        req_q;
  logic        we_q;
  logic [15:0] maddr_q;
  logic [7:0]  mwdata_q;

  assign start_op_d = op_class(d_inst);
  // Byte loads finish on the BYTE0 ack, so the low byte comes straight off the bus there.
  assign byte_lo_d  = (state_q == BYTE0) ? bus.mem_rdata : lo_q;

  load_extend u_load_extend (
    .op_i      (op_q),
    .byte_lo_i (byte_lo_d),
    .byte_hi_i (bus.mem_rdata),
    .rdata_o   (rdata_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= NOP;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q       <= start_op_d;
            addr_q     <= addr;
            wdata_hi_q <= wdata[15:8];
            busy_q     <= 1'b1;
            if (start_op_d == NOP) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= BYTE0;
              req_q    <= 1'b1;
              we_q     <= is_store(start_op_d);
              maddr_q  <= addr;
              mwdata_q <= wdata[7:0];
            end
          end
        end
        BYTE0: begin
          if (bus.mem_ack) begin
            lo_q <= bus.mem_rdata;
            if (is_word(op_q)) begin
              state_q  <= BYTE1;
              maddr_q  <= addr_q + 16'd1;
              mwdata_q <= wdata_hi_q;
            end else begin
              state_q <= DONE;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              if (is_load(op_q)) rdata_q <= rdata_d;
            end
          end
        end
        BYTE1: begin
          if (bus.mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            if (is_load(op_q)) rdata_q <= rdata_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign state_o       = state_q;
endmodule
